// File: rtl/sbox.sv
// PRINCE 4-bit S-box; d selects the inverse mapping.
module sbox (
  input  logic [3:0] a,
  input  logic       d,
  output logic [3:0] y
);

  always_comb begin
    y = 4'h0;
    if (!d) begin
      case (a)
        4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
        4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
        4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
        4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  4'hF: y = 4'h4;
        default: y = 4'h0;
      endcase
    end else begin
      case (a)
        4'h0: y = 4'hB;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
        4'h4: y = 4'hF;  4'h5: y = 4'hD;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
        4'h8: y = 4'hA;  4'h9: y = 4'h6;  4'hA: y = 4'h4;  4'hB: y = 4'h0;
        4'hC: y = 4'h5;  4'hD: y = 4'hE;  4'hE: y = 4'hC;  4'hF: y = 4'h1;
        default: y = 4'h0;
      endcase
    end
  end

endmodule

// File: rtl/prince_slayer_serial.sv
// Iterative PRINCE S-layer: substitutes SBOX_PAR nibbles per cycle by rotating
// the 64-bit work register through a bank of sbox instances.
module prince_slayer_serial #(
  parameter int unsigned SBOX_PAR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:63] in_state,
  input  logic        in_dec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:63] out_state,
  output logic        busy
);

  localparam int unsigned NSTEP  = 16 / SBOX_PAR;
  localparam int unsigned CNT_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int unsigned STEP_W = 4 * SBOX_PAR;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSTEP - 1);

  if (SBOX_PAR != 1 && SBOX_PAR != 2 && SBOX_PAR != 4 &&
      SBOX_PAR != 8 && SBOX_PAR != 16) begin : g_bad_par
    $error("prince_slayer_serial: SBOX_PAR must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_in_ready;
  logic               w_accept;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dec;
  logic [63:0]        r_work;
  logic [STEP_W-1:0]  w_sub;
  logic [63:0]        w_rot;

  // Leading nibbles of the work register go through the sbox bank.
  for (genvar j = 0; j < int'(SBOX_PAR); j++) begin : g_sbox
    sbox u_sbox (
      .a (r_work[63-4*j -: 4]),
      .d (r_dec),
      .y (w_sub[STEP_W-1-4*j -: 4])
    );
  end

  if (SBOX_PAR == 16) begin : g_rot_full
    assign w_rot = w_sub;
  end else begin : g_rot_part
    assign w_rot = {r_work[63-STEP_W:0], w_sub};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // DONE may hand off straight to BUSY when downstream drains and upstream offers.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (r_cnt == LAST) w_state_nxt = DONE;
      end
      DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? BUSY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_accept = in_valid & w_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= 64'h0;
      r_cnt  <= '0;
      r_dec  <= 1'b0;
    end else if (w_accept) begin
      r_work <= in_state;
      r_dec  <= in_dec;
      r_cnt  <= '0;
    end else if (r_state == BUSY) begin
      r_work <= w_rot;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == BUSY);
  assign out_state = r_work;

endmodule
